// File: rtl/fp_add_sub_pipe.sv
// rtl/fp_add_sub_pipe.sv - 3-stage pipelined IEEE-754 adder/subtractor with global stall
// Define FP_ADD_SUB_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_add_sub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a_operand,
   input  logic [EXP_W+MAN_W:0]   b_operand,
   input  logic                   AddBar_Sub,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [TAG_W-1:0]       out_tag,
   output logic                   overflow,
   output logic                   invalid
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int SW  = MAN_W + 4;
   localparam int EW  = EXP_W + 2;
   localparam int LZW = $clog2(SW + 1);
   localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             sign;
      logic             sub;
      logic             nan;
      logic             inf;
      logic             inf_sign;
      logic [EXP_W-1:0] exp;
      logic [SW-1:0]    x;
      logic [SW-1:0]    y;
   } s1_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             sign;
      logic             sub;
      logic             nan;
      logic             inf;
      logic             inf_sign;
      logic [EXP_W-1:0] exp;
      logic [SW:0]      sum;
   } s2_t;

   function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
      logic [LZW-1:0] n;
      n = LZW'(SW);
      for (int i = 0; i < SW; i++) begin
         if (v[i]) n = LZW'(SW - 1 - i);
      end
      return n;
   endfunction

   logic             advance;
   logic             s1_valid_d, s1_valid_q;
   logic             s2_valid_d, s2_valid_q;
   s1_t              s1_d, s1_q, s1_new;
   s2_t              s2_d, s2_q, s2_new;
   logic             out_valid_d, out_valid_q;
   logic [W-1:0]     result_d, result_q;
   logic [TAG_W-1:0] out_tag_d, out_tag_q;
   logic             overflow_d, overflow_q;
   logic             invalid_d, invalid_q;

   assign advance   = !out_valid_q | out_ready;
   assign in_ready  = advance;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign out_tag   = out_tag_q;
   assign overflow  = overflow_q;
   assign invalid   = invalid_q;

   logic             a_sign, b_sign;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_man, b_man;
   logic             a_nan, b_nan, a_inf, b_inf, a_big;
   logic [EXP_W-1:0] a_exp_eff, b_exp_eff, x_exp, y_exp, exp_diff;
   logic [MAN_W:0]   a_sig, b_sig, x_sig, y_sig;
   logic             x_sign;
   logic [SW-1:0]    y_ext, y_shr, y_lost, y_aligned;

   always_comb begin
      a_sign    = a_operand[W-1];
      b_sign    = b_operand[W-1] ^ AddBar_Sub;
      a_exp     = a_operand[W-2:MAN_W];
      b_exp     = b_operand[W-2:MAN_W];
      a_man     = a_operand[MAN_W-1:0];
      b_man     = b_operand[MAN_W-1:0];
      a_nan     = (&a_exp) & (|a_man);
      b_nan     = (&b_exp) & (|b_man);
      a_inf     = (&a_exp) & ~(|a_man);
      b_inf     = (&b_exp) & ~(|b_man);
      // Subnormals: hidden bit 0, effective exponent 1
      a_exp_eff = (a_exp == '0) ? EXP_W'(1) : a_exp;
      b_exp_eff = (b_exp == '0) ? EXP_W'(1) : b_exp;
      a_sig     = {|a_exp, a_man};
      b_sig     = {|b_exp, b_man};
      a_big     = (a_operand[W-2:0] >= b_operand[W-2:0]);
      if (a_big) begin
         x_sign = a_sign;
         x_exp  = a_exp_eff;
         x_sig  = a_sig;
         y_exp  = b_exp_eff;
         y_sig  = b_sig;
      end else begin
         x_sign = b_sign;
         x_exp  = b_exp_eff;
         x_sig  = b_sig;
         y_exp  = a_exp_eff;
         y_sig  = a_sig;
      end
      exp_diff = x_exp - y_exp;
      y_ext    = {y_sig, 3'b000};
      y_shr    = y_ext >> exp_diff;
      y_lost   = y_ext & ~({SW{1'b1}} << exp_diff);
      if (32'(exp_diff) >= 32'(SW - 1)) begin
         y_aligned = {{(SW-1){1'b0}}, |y_sig};
      end else begin
         y_aligned = {y_shr[SW-1:1], y_shr[0] | (|y_lost)};
      end

      s1_new.tag      = in_tag;
      s1_new.sign     = x_sign;
      s1_new.sub      = a_sign ^ b_sign;
      s1_new.nan      = a_nan | b_nan | (a_inf & b_inf & (a_sign ^ b_sign));
      s1_new.inf      = (a_inf | b_inf) & ~s1_new.nan;
      s1_new.inf_sign = a_inf ? a_sign : b_sign;
      s1_new.exp      = x_exp;
      s1_new.x        = {x_sig, 3'b000};
      s1_new.y        = y_aligned;
   end

   always_comb begin
      s2_new.tag      = s1_q.tag;
      s2_new.sign     = s1_q.sign;
      s2_new.sub      = s1_q.sub;
      s2_new.nan      = s1_q.nan;
      s2_new.inf      = s1_q.inf;
      s2_new.inf_sign = s1_q.inf_sign;
      s2_new.exp      = s1_q.exp;
      if (s1_q.sub) s2_new.sum = {1'b0, s1_q.x} - {1'b0, s1_q.y};
      else          s2_new.sum = {1'b0, s1_q.x} + {1'b0, s1_q.y};
   end

   logic [LZW-1:0]   lz;
   logic [EW-1:0]    exp_w, cap, shamt, exp_n, exp_f;
   logic [SW-1:0]    norm;
   logic [MAN_W+1:0] rnd;
   logic [MAN_W-1:0] man_f;
   logic             sign_f;
   logic [W-1:0]     s3_result;
   logic             s3_ovf, s3_inv;

   always_comb begin
      lz    = lzc(s2_q.sum[SW-1:0]);
      exp_w = EW'(s2_q.exp);
      cap   = exp_w - EW'(1);
      shamt = '0;
      if (s2_q.sum[SW]) begin
         norm  = {s2_q.sum[SW:2], s2_q.sum[1] | s2_q.sum[0]};
         exp_n = exp_w + EW'(1);
      end else begin
         // Left shift never takes the biased exponent below 1
         shamt = (EW'(lz) < cap) ? EW'(lz) : cap;
         norm  = s2_q.sum[SW-1:0] << shamt;
         exp_n = exp_w - shamt;
      end
`ifdef FP_ADD_SUB_RNE_EN
      rnd = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(norm[2] & (norm[1] | norm[0] | norm[3]));
`else
      rnd = {1'b0, norm[SW-1:3]};
`endif
      if (rnd[MAN_W+1]) begin
         man_f = rnd[MAN_W:1];
         exp_f = exp_n + EW'(1);
      end else begin
         man_f = rnd[MAN_W-1:0];
         exp_f = rnd[MAN_W] ? exp_n : '0;
      end
      sign_f = (s2_q.sum == '0) ? (s2_q.sign & ~s2_q.sub) : s2_q.sign;

      s3_ovf = 1'b0;
      s3_inv = 1'b0;
      if (s2_q.nan) begin
         s3_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         s3_inv    = 1'b1;
      end else if (s2_q.inf) begin
         s3_result = {s2_q.inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (exp_f >= EXP_MAX) begin
         s3_result = {sign_f, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         s3_ovf    = 1'b1;
      end else begin
         s3_result = {sign_f, exp_f[EXP_W-1:0], man_f};
      end
   end

`ifndef FP_ADD_SUB_RNE_EN
   logic grs_unused;
   assign grs_unused = ^norm[2:0];
`endif

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_d        = s1_q;
      s2_valid_d  = s2_valid_q;
      s2_d        = s2_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      out_tag_d   = out_tag_q;
      overflow_d  = overflow_q;
      invalid_d   = invalid_q;
      if (advance) begin
         s1_valid_d  = in_valid;
         s1_d        = s1_new;
         s2_valid_d  = s1_valid_q;
         s2_d        = s2_new;
         out_valid_d = s2_valid_q;
         result_d    = s3_result;
         out_tag_d   = s2_q.tag;
         overflow_d  = s3_ovf;
         invalid_d   = s3_inv;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         s2_valid_q  <= 1'b0;
         s2_q        <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         out_tag_q   <= '0;
         overflow_q  <= 1'b0;
         invalid_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_q        <= s1_d;
         s2_valid_q  <= s2_valid_d;
         s2_q        <= s2_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         out_tag_q   <= out_tag_d;
         overflow_q  <= overflow_d;
         invalid_q   <= invalid_d;
      end
   end
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// tb/tb_fp_add_sub_pipe.sv - self-checking bench for fp_add_sub_pipe (default parameters)
module tb_fp_add_sub_pipe;
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] res;
      logic        ovf;
      logic        inv;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        inv;
      logic [3:0]  tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a_operand = '0;
   logic [31:0] b_operand = '0;
   logic        add_sub = 1'b0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic [3:0]  out_tag;
   logic        overflow;
   logic        invalid;

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   exp_t        mon_e;
   vec_t        vecs[24];
   logic        prev_stall = 1'b0;
   logic [37:0] prev_out = '0;

   always #5 clk = ~clk;

   fp_add_sub_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_operand(a_operand), .b_operand(b_operand), .AddBar_Sub(add_sub),
      .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .out_tag(out_tag), .overflow(overflow), .invalid(invalid)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                               input logic [31:0] res, input logic ovf, input logic inv);
      vec_t v;
      v.a = a; v.b = b; v.sub = sub; v.res = res; v.ovf = ovf; v.inv = inv;
      return v;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check("hold_while_stalled", {result, out_tag, overflow, invalid}, prev_out);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got tag %0h result %h, required no output", out_tag, result);
            end else begin
               mon_e = exp_q.pop_front();
               check("result_tag_flags", {result, out_tag, overflow, invalid},
                     {mon_e.res, mon_e.tag, mon_e.ovf, mon_e.inv});
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {result, out_tag, overflow, invalid};
      end
   end

   task automatic send(input vec_t v, input logic [3:0] tag, input bit track);
      int   n;
      exp_t e;
      a_operand = v.a;
      b_operand = v.b;
      add_sub   = v.sub;
      in_tag    = tag;
      in_valid  = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready 0 for 200 cycles, required 1");
      end else if (track) begin
         e.res = v.res; e.ovf = v.ovf; e.inv = v.inv; e.tag = tag;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

   initial begin
      bit seen;
      vecs[0]  = mk(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
      vecs[1]  = mk(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
      vecs[2]  = mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
      vecs[3]  = mk(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1);
      vecs[4]  = mk(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1);
`ifdef FP_ADD_SUB_RNE_EN
      vecs[5]  = mk(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0);
      vecs[18] = mk(32'h4B800000, 32'h40400000, 1'b0, 32'h4B800002, 1'b0, 1'b0);
      vecs[19] = mk(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
`else
      vecs[5]  = mk(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800001, 1'b0, 1'b0);
      vecs[18] = mk(32'h4B800000, 32'h40400000, 1'b0, 32'h4B800001, 1'b0, 1'b0);
      vecs[19] = mk(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h3FFFFFFF, 1'b0, 1'b0);
`endif
      vecs[6]  = mk(32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
      vecs[7]  = mk(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0);
      vecs[8]  = mk(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0);
      vecs[9]  = mk(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0);
      vecs[10] = mk(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
      vecs[11] = mk(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0);
      vecs[12] = mk(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0);
      vecs[13] = mk(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);
      vecs[14] = mk(32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 1'b0, 1'b0);
      vecs[15] = mk(32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 1'b0, 1'b0);
      vecs[16] = mk(32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 1'b0, 1'b0);
      vecs[17] = mk(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 1'b0);
      vecs[20] = mk(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 1'b0, 1'b0);
      vecs[21] = mk(32'h3F800000, 32'hFFC00000, 1'b0, 32'h7FC00000, 1'b0, 1'b1);
      vecs[22] = mk(32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0);
      vecs[23] = mk(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {out_valid, result, out_tag, overflow, invalid}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready_after_reset", 64'(in_ready), 64'd1);

      send(vecs[0], 4'hA, 1'b1);
      check("latency_edge1", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check("latency_edge2", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check("latency_edge3", {out_valid, result, overflow, invalid}, {1'b1, 32'h40000000, 1'b0, 1'b0});
      drain();

      for (int i = 0; i < 24; i++) send(vecs[i], 4'(i), 1'b1);
      drain();

      fork
         begin
            for (int i = 0; i < 24; i++) send(vecs[23 - i], 4'(i), 1'b1);
         end
         begin
            repeat (70) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      out_ready = 1'b0;
      for (int t = 1; t <= 3; t++) send(vecs[t + 5], 4'(t), 1'b1);
      check("stall_in_ready_low", {in_ready, out_valid, out_tag}, {1'b0, 1'b1, 4'd1});
      repeat (3) begin
         @(posedge clk); #1;
         check("stall_hold", {in_ready, out_valid, out_tag}, {1'b0, 1'b1, 4'd1});
      end
      out_ready = 1'b1;
      send(vecs[9], 4'd4, 1'b1);
      drain();

      out_ready = 1'b0;
      for (int t = 5; t <= 7; t++) send(vecs[t], 4'(t), 1'b0);
      check("inflight_before_reset", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_clears", {out_valid, result, out_tag, overflow, invalid}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_reset_release", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("no_output_after_reset", 64'(seen), 64'd0);
      @(posedge clk); #1;
      send(vecs[20], 4'hC, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
